// File: rtl/mac_feed.sv
// mac_feed: multiplies a valid/ready stream of signed operand pairs and sequences the
// downstream sig/data/isStop command bus. Optional build macro MAC_FEED_SKIPZERO_EN.
module mac_feed #(
    parameter int DW      = 16,
    parameter int MAX_LEN = 256,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_last,
    output logic [2:0]           sig,
    output logic [31:0]          data,
    output logic                 isStop,
    output logic [CW-1:0]        beat_cnt,
    output logic                 len_err
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_END, S_OUT} state_t;

    localparam logic [2:0]    SIG_IDLE  = 3'b000;
    localparam logic [2:0]    SIG_ACC   = 3'b001;
    localparam logic [2:0]    SIG_OUT   = 3'b010;
    localparam logic [2:0]    SIG_START = 3'b011;
    localparam logic [2:0]    SIG_END   = 3'b100;
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_LEN - 1);

    state_t               state, state_nx;
    logic                 accept, at_max, eff_last, emit_p0;
    logic [CW-1:0]        cnt_base, cnt_nx;
    logic [2:0]           sig_nx;
    logic                 stop_nx, ready_nx, err_nx;
    logic                 vld_p0;
    logic signed [DW-1:0] a_p0, b_p0;

    function automatic logic [31:0] sext_prod(input logic signed [DW-1:0] a,
                                              input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return 32'(p);
    endfunction

    assign accept   = in_valid && in_ready;
    // a vector's first beat always counts as beat 1, whatever the previous vector left behind
    assign cnt_base = (state == S_IDLE) ? '0 : beat_cnt;
    assign at_max   = (cnt_base == CNT_LAST);
    assign eff_last = in_last || at_max;

`ifdef MAC_FEED_SKIPZERO_EN
    logic zero_p0;

    always_ff @(posedge clk) begin
        if (accept) zero_p0 <= (in_a == '0) || (in_b == '0);
    end

    assign emit_p0 = vld_p0 && !zero_p0;
`else
    assign emit_p0 = vld_p0;
`endif

    always_comb begin
        state_nx = state;
        sig_nx   = emit_p0 ? SIG_ACC : SIG_IDLE;
        stop_nx  = 1'b0;
        cnt_nx   = beat_cnt;
        err_nx   = len_err;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    sig_nx   = SIG_START;
                    cnt_nx   = CW'(1);
                    err_nx   = at_max && !in_last;
                    state_nx = eff_last ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_nx = beat_cnt + 1'b1;
                    if (at_max && !in_last) err_nx = 1'b1;
                    if (eff_last) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // the last product leaves on the edge that clears vld_p0
                if (!vld_p0) begin
                    sig_nx   = SIG_END;
                    stop_nx  = 1'b1;
                    state_nx = S_END;
                end
            end
            S_END: begin
                sig_nx   = SIG_OUT;
                stop_nx  = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        ready_nx = (state_nx == S_IDLE) || (state_nx == S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // stage p0: operand capture
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= in_a;
            b_p0 <= in_b;
        end
    end

    // stage p1: registered command bus and product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0   <= 1'b0;
            sig      <= SIG_IDLE;
            data     <= '0;
            isStop   <= 1'b0;
            in_ready <= 1'b0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            vld_p0   <= accept;
            sig      <= sig_nx;
            isStop   <= stop_nx;
            in_ready <= ready_nx;
            beat_cnt <= cnt_nx;
            len_err  <= err_nx;
            if (emit_p0) data <= sext_prod(a_p0, b_p0);
        end
    end

endmodule

// File: tb/tb_mac_feed.sv
// Scoreboard bench for mac_feed: a cycle-timed event model of the command bus,
// fed by directed and randomized operand streams.
module tb_mac_feed;
    localparam int DW      = 16;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic signed [DW-1:0] in_a = '0;
    logic signed [DW-1:0] in_b = '0;
    logic                 in_ready;
    logic [2:0]           sig;
    logic [31:0]          data;
    logic                 isStop;
    logic [CW-1:0]        beat_cnt;
    logic                 len_err;

    mac_feed #(.DW(DW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .sig(sig), .data(data),
        .isStop(isStop), .beat_cnt(beat_cnt), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [2:0] sig; logic [31:0] data;} ev_t;
    typedef struct {int cyc; int cnt; logic err;} cnt_t;

    ev_t  ev_q[$];
    cnt_t cnt_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_at = 1 << 30;
    bit   in_vec = 0;
    int   vec_n = 0;
    logic vec_err = 1'b0;
    logic [31:0] data_exp = '0;
    int   cnt_exp = 0;
    logic err_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // reference model: a beat accepted at edge k schedules its command-bus events
    task automatic model_accept(input int a, input int b, input bit last, input int k);
        ev_t  e;
        cnt_t c;
        int   p;
        if (!in_vec) begin
            e.cyc = k; e.sig = 3'b011; e.data = '0;
            ev_q.push_back(e);
            in_vec  = 1;
            vec_n   = 0;
            vec_err = 1'b0;
        end
        vec_n++;
        if (!last && vec_n == MAX_LEN) vec_err = 1'b1;
        c.cyc = k; c.cnt = vec_n; c.err = vec_err;
        cnt_q.push_back(c);
        p = a * b;
`ifdef MAC_FEED_SKIPZERO_EN
        if (a != 0 && b != 0) begin
            e.cyc = k + 1; e.sig = 3'b001; e.data = p;
            ev_q.push_back(e);
        end
`else
        e.cyc = k + 1; e.sig = 3'b001; e.data = p;
        ev_q.push_back(e);
`endif
        if (last || vec_n == MAX_LEN) begin
            e.cyc = k + 2; e.sig = 3'b100; e.data = '0;
            ev_q.push_back(e);
            e.cyc = k + 3; e.sig = 3'b010;
            ev_q.push_back(e);
            in_vec   = 0;
            ready_at = k + 4;
        end
    endtask

    always @(posedge clk) begin
        ev_t         e;
        cnt_t        c;
        logic [2:0]  es;
        #2;
        if (!rst) begin
            chk("rst_sig", 32'(sig), 32'h0);
            chk("rst_data", data, 32'h0);
            chk("rst_isStop", 32'(isStop), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
            chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
            chk("rst_len_err", 32'(len_err), 32'h0);
        end else begin
            es = 3'b000;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e  = ev_q.pop_front();
                es = e.sig;
                if (es == 3'b001) data_exp = e.data;
            end
            while (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
                c       = cnt_q.pop_front();
                cnt_exp = c.cnt;
                err_exp = c.err;
            end
            chk("sig", 32'(sig), 32'(es));
            chk("isStop", 32'(isStop), 32'(es == 3'b100 || es == 3'b010));
            chk("data", data, data_exp);
            chk("in_ready", 32'(in_ready), 32'(cyc >= ready_at));
            chk("beat_cnt", 32'(beat_cnt), 32'(cnt_exp));
            chk("len_err", 32'(len_err), 32'(err_exp));
        end
    end

    task automatic send(input int a, input int b, input bit last, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a[DW-1:0];
            in_b     = b[DW-1:0];
            in_last  = last;
            if (cyc >= ready_at) begin
                model_accept(a, b, last, cyc + 1);
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout at cycle %0d: got no accept, expected one within 40 cycles", cyc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ev_q.delete();
        cnt_q.delete();
        in_vec   = 0;
        data_exp = '0;
        cnt_exp  = 0;
        err_exp  = 1'b0;
        ready_at = 1 << 30;
        repeat (n) @(negedge clk);
        rst      = 1'b1;
        ready_at = cyc + 1;
    endtask

    function automatic int rand_op();
        logic signed [15:0] t;
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return -32768;
            2:       return 32767;
            default: begin
                t = 16'($urandom);
                return int'(t);
            end
        endcase
    endfunction

    initial begin
        int len;
        repeat (3) @(negedge clk);
        rst      = 1'b1;
        ready_at = cyc + 1;

        send(3, 4, 0, 0);
        send(-2, 5, 0, 0);
        send(7, -1, 1, 0);
        send(-32768, -32768, 1, 0);
        send(6, 7, 0, 0);
        send(-3, 3, 1, 2);
        for (int i = 0; i < 6; i++) send(i + 1, -(i + 2), 0, 0);
        send(11, 11, 1, 0);
        send(2, 3, 0, 1);
        send(0, 9, 0, 0);
        send(4, 5, 1, 0);

        send(8, 9, 0, 1);
        send(10, -10, 0, 0);
        do_reset(3);

        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                send(rand_op(), rand_op(), i == len - 1, $urandom_range(0, 2));
        end

        @(negedge clk);
        in_valid = 1'b0;
        for (int w = 0; w < 40 && (ev_q.size() > 0 || cnt_q.size() > 0); w++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(ev_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
